food_placer: RTL and testbench
==============================

Name: food_placer

Overview:
- Consumes the snake's per-cycle body-position stream (head first, tail last, one element per clock) and owns the food item.
- Detects when the new head lands on the food and pulses o_eat back into the snake so its length grows.
- Draws a pseudo-random replacement cell and validates it against one full body pass before publishing it.
- Sits between the snake block and the renderer/game controller.

Parameters:
- GAME_WIDTH, 20, playable columns; legal x is 1..GAME_WIDTH (0 and GAME_WIDTH+1 are border); must be ≤30.
- GAME_HEIGHT, 14, playable rows; legal y is 1..GAME_HEIGHT; must be ≤14.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_pos_x  in  5  current body element x
- i_pos_y  in  4  current body element y
- i_pos_first  in  1  element is the head (start of pass)
- i_pos_last  in  1  element is the tail (end of pass)
- i_pos_valid  in  1  element fields valid this cycle
- i_success  in  1  snake fills the board; stop placing food
- o_eat  out  1  one-cycle pulse: head hit food
- o_food_x  out  5  food column
- o_food_y  out  4  food row
- o_food_valid  out  1  food is placed and displayable

Behaviour:
- Reset (async, immediate): state=DRAW, lfsr=LFSR_SEED, o_eat=0, o_food_valid=0, o_food_x=0, o_food_y=0.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Advances every clock in every state.
- Candidate: cx=lfsr[4:0], cy=lfsr[11:8].
- A "beat" is a cycle with i_pos_valid=1. "Head beat" = beat with i_pos_first=1. "Tail beat" = beat with i_pos_last=1.
- States:
  - DRAW: if 1≤cx≤GAME_WIDTH and 1≤cy≤GAME_HEIGHT, latch cx/cy into o_food_x/o_food_y and go to SYNC. Otherwise stay in DRAW and retry next cycle.
  - SYNC: wait for a head beat, then check that beat exactly as CHECK does.
  - CHECK: on any beat where (i_pos_x,i_pos_y)==(o_food_x,o_food_y), go to DRAW (collision). On a tail beat with no match, set o_food_valid=1 and go to ACTIVE. A single-element snake (head beat is also tail beat) resolves in SYNC within one cycle.
  - ACTIVE: on a head beat matching the food, o_eat=1 for the next cycle only, o_food_valid=0, go to DRAW.
  - DONE: o_food_valid=0, o_eat=0; left only by reset.
- o_eat is registered, asserted the cycle after the matching head beat, width exactly 1 clock. It never asserts outside an ACTIVE→DRAW transition.
- o_food_x/o_food_y hold their value in ACTIVE. They may change in DRAW, SYNC and CHECK while o_food_valid=0.
- i_success=1 in any state moves to DONE next cycle and takes priority over all other transitions. No o_eat is issued in that cycle.
- Beats with i_pos_valid=0 are ignored in all states.
- A board with no free cell and no i_success loops DRAW↔CHECK indefinitely. This is legal.

Decomposition:
- Shared package: GAME_WIDTH, GAME_HEIGHT, FOOD_LFSR_SEED constants; typedef food_state_t {DRAW, SYNC, CHECK, ACTIVE, DONE}.
- Sub-module lfsr16 (clk, rst, seed parameter, 16-bit state out).
- Top level holds the FSM and the compare logic.

Test Plan:
- Reset: assert rst mid-CHECK → same-cycle o_food_valid=0, o_eat=0, o_food_x=0. After release, the lfsr model sequence restarts from 16'hACE1.
- Placement: single-element snake at (3,3), food candidate ≠(3,3) → o_food_valid=1 after the first head beat; o_food_x∈1..20, o_food_y∈1..14.
- Eat: food at (5,7), head beat at (5,7) → o_eat=1 exactly one cycle later, o_food_valid=0 the same cycle, new placement follows.
- Collision retry: body stream contains the candidate cell at element 4 → o_food_valid stays 0 and FSM returns to DRAW. Bench LFSR model predicts the next accepted candidate.
- Range: 1000 random eat cycles → o_food_x never 0 or >20, o_food_y never 0 or >14. Food never coincides with any element of the validating pass.
- Success: i_success=1 while ACTIVE with head on food → no o_eat pulse, o_food_valid=0 next cycle, remains 0 until reset.

Source files
------------

// File: rtl/food_placer_pkg.sv
// Shared constants and types for the food placer: board geometry, LFSR seed and FSM states.
package food_placer_pkg;

    localparam int unsigned GAME_WIDTH     = 20;
    localparam int unsigned GAME_HEIGHT    = 14;
    localparam logic [15:0] FOOD_LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        DRAW,
        SYNC,
        CHECK,
        ACTIVE,
        DONE
    } food_state_t;

    // Fibonacci step for x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/food_placer_if.sv
// Body-position stream from the snake plus the food/eat signals returned to it.
interface food_placer_if;

    logic [4:0] i_pos_x;
    logic [3:0] i_pos_y;
    logic       i_pos_first;
    logic       i_pos_last;
    logic       i_pos_valid;
    logic       i_success;
    logic       o_eat;
    logic [4:0] o_food_x;
    logic [3:0] o_food_y;
    logic       o_food_valid;

    modport master (
        output i_pos_x, i_pos_y, i_pos_first, i_pos_last, i_pos_valid, i_success,
        input  o_eat, o_food_x, o_food_y, o_food_valid
    );

    modport slave (
        input  i_pos_x, i_pos_y, i_pos_first, i_pos_last, i_pos_valid, i_success,
        output o_eat, o_food_x, o_food_y, o_food_valid
    );

endinterface

// File: rtl/food_placer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the food-position random source.
module lfsr16
    import food_placer_pkg::*;
#(
    parameter logic [15:0] SEED = FOOD_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/food_placer.sv
// Food placement FSM: draws a random cell, validates it against one full body pass,
// publishes it, and pulses eat when the head lands on it.
module food_placer
    import food_placer_pkg::*;
#(
    parameter int unsigned GAME_WIDTH  = food_placer_pkg::GAME_WIDTH,
    parameter int unsigned GAME_HEIGHT = food_placer_pkg::GAME_HEIGHT,
    parameter logic [15:0] LFSR_SEED   = FOOD_LFSR_SEED
) (
    input  logic         clk,
    input  logic         rst,
    food_placer_if.slave bus
);

    localparam logic [4:0] MAX_X = 5'(GAME_WIDTH);
    localparam logic [3:0] MAX_Y = 4'(GAME_HEIGHT);

    food_state_t state;
    logic [15:0] lfsr;
    logic [4:0]  cand_x;
    logic [3:0]  cand_y;
    logic        cand_ok;
    logic        beat;
    logic        head;
    logic        tail;
    logic        hit;
    logic        unused_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign cand_x      = lfsr[4:0];
    assign cand_y      = lfsr[11:8];
    assign unused_lfsr = ^{lfsr[15:12], lfsr[7:5]};
    assign cand_ok     = (cand_x != 5'd0) && (cand_x <= MAX_X) &&
                         (cand_y != 4'd0) && (cand_y <= MAX_Y);

    assign beat = bus.i_pos_valid;
    assign head = beat && bus.i_pos_first;
    assign tail = beat && bus.i_pos_last;
    assign hit  = beat && (bus.i_pos_x == bus.o_food_x) && (bus.i_pos_y == bus.o_food_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= DRAW;
            bus.o_eat        <= 1'b0;
            bus.o_food_valid <= 1'b0;
            bus.o_food_x     <= 5'd0;
            bus.o_food_y     <= 4'd0;
        end else begin
            bus.o_eat <= 1'b0;
            if (bus.i_success) begin
                state            <= DONE;
                bus.o_food_valid <= 1'b0;
            end else begin
                case (state)
                    DRAW: begin
                        if (cand_ok) begin
                            bus.o_food_x <= cand_x;
                            bus.o_food_y <= cand_y;
                            state        <= SYNC;
                        end
                    end
                    // The head beat of SYNC is checked exactly like a CHECK beat.
                    SYNC: begin
                        if (head) begin
                            if (hit) begin
                                state <= DRAW;
                            end else if (tail) begin
                                bus.o_food_valid <= 1'b1;
                                state            <= ACTIVE;
                            end else begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (hit) begin
                            state <= DRAW;
                        end else if (tail) begin
                            bus.o_food_valid <= 1'b1;
                            state            <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (head && hit) begin
                            bus.o_eat        <= 1'b1;
                            bus.o_food_valid <= 1'b0;
                            state            <= DRAW;
                        end
                    end
                    default: begin
                        bus.o_food_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_food_placer.sv
// Directed self-checking bench for food_placer, with an independent LFSR model for placement.
module tb_food_placer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    food_placer_if bus ();

    food_placer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] lfsr_m;
    logic [4:0]  fx;
    logic [3:0]  fy;
    logic [4:0]  px [16];
    logic [3:0]  py [16];
    bit          col;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form.
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.i_pos_valid = 1'b0;
        bus.i_pos_first = 1'b0;
        bus.i_pos_last  = 1'b0;
    endtask

    task automatic drive(input logic [4:0] x, input logic [3:0] y, input logic f,
                         input logic l);
        bus.i_pos_x     = x;
        bus.i_pos_y     = y;
        bus.i_pos_first = f;
        bus.i_pos_last  = l;
        bus.i_pos_valid = 1'b1;
    endtask

    // Called at a negedge with the DUT in DRAW; predicts and checks the latched candidate.
    task automatic place();
        logic [4:0] cx;
        logic [3:0] cy;
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            cx = lfsr_m[4:0];
            cy = lfsr_m[11:8];
            if (cx >= 1 && cx <= 20 && cy >= 1 && cy <= 14) begin
                found = 1;
                fx    = cx;
                fy    = cy;
            end
            @(negedge clk);
        end
        if (!found) begin
            total++;
            bad++;
            $error("FAIL place_timeout observed=none expected=candidate");
        end
        chk("food_x", 16'(bus.o_food_x), 16'(fx));
        chk("food_y", 16'(bus.o_food_y), 16'(fy));
        chk("valid_in_sync", 16'(bus.o_food_valid), 16'd0);
        chk("x_range", 16'(bus.o_food_x >= 5'd1 && bus.o_food_x <= 5'd20), 16'd1);
        chk("y_range", 16'(bus.o_food_y >= 4'd1 && bus.o_food_y <= 4'd14), 16'd1);
    endtask

    // Streams px/py[0..n-1]; stops at the first element equal to the food.
    task automatic run_pass(input int n, output bit collided);
        collided = 0;
        for (int k = 0; k < n; k++) begin
            drive(px[k], py[k], k == 0, k == n - 1);
            @(negedge clk);
            if (px[k] == fx && py[k] == fy) begin
                chk("valid_collide", 16'(bus.o_food_valid), 16'd0);
                collided = 1;
                break;
            end else if (k == n - 1) begin
                chk("valid_tail", 16'(bus.o_food_valid), 16'd1);
            end else begin
                chk("valid_mid", 16'(bus.o_food_valid), 16'd0);
            end
        end
        idle();
    endtask

    task automatic place_random();
        int tries = 0;
        int n;
        do begin
            place();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                px[k] = 5'($urandom_range(1, 20));
                py[k] = 4'($urandom_range(1, 14));
            end
            run_pass(n, col);
            tries++;
        end while (col && tries < 50);
    endtask

    task automatic eat();
        drive(fx, fy, 1'b1, 1'($urandom_range(0, 1)));
        @(negedge clk);
        chk("eat_pulse", 16'(bus.o_eat), 16'd1);
        chk("eat_valid", 16'(bus.o_food_valid), 16'd0);
        idle();
        place();
        chk("eat_width", 16'(bus.o_eat), 16'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_success = 1'b0;
        bus.i_pos_x   = 5'd0;
        bus.i_pos_y   = 4'd0;
        idle();
        #12;
        chk("rst_valid", 16'(bus.o_food_valid), 16'd0);
        chk("rst_eat", 16'(bus.o_eat), 16'd0);
        chk("rst_x", 16'(bus.o_food_x), 16'd0);
        chk("rst_y", 16'(bus.o_food_y), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Seed 16'hACE1 gives (1,12) on the first DRAW cycle.
        place();
        chk("first_x", 16'(bus.o_food_x), 16'd1);
        chk("first_y", 16'(bus.o_food_y), 16'd12);

        // Single-element snake at (3,3).
        px[0] = 5'd3;
        py[0] = 4'd3;
        run_pass(1, col);

        // Non-matching head and an invalid beat on the food: no eat, food held.
        drive(5'd0, 4'd1, 1'b1, 1'b1);
        @(negedge clk);
        chk("miss_eat", 16'(bus.o_eat), 16'd0);
        chk("miss_valid", 16'(bus.o_food_valid), 16'd1);
        drive(fx, fy, 1'b1, 1'b1);
        bus.i_pos_valid = 1'b0;
        @(negedge clk);
        chk("novalid_eat", 16'(bus.o_eat), 16'd0);
        chk("novalid_valid", 16'(bus.o_food_valid), 16'd1);
        chk("hold_x", 16'(bus.o_food_x), 16'(fx));
        idle();

        // Eat, then collision at element 4 of a 5-element pass.
        eat();
        for (int k = 0; k < 4; k++) begin
            px[k] = 5'd0;
            py[k] = 4'(k + 1);
        end
        px[4] = fx;
        py[4] = fy;
        run_pass(5, col);
        place();
        for (int k = 0; k < 5; k++) begin
            px[k] = 5'd0;
            py[k] = 4'(k + 1);
        end
        run_pass(5, col);

        for (int it = 0; it < 1000; it++) begin
            drive(fx, fy, 1'b1, 1'($urandom_range(0, 1)));
            @(negedge clk);
            chk("loop_eat", 16'(bus.o_eat), 16'd1);
            chk("loop_valid", 16'(bus.o_food_valid), 16'd0);
            idle();
            place_random();
        end

        // Success overrides an eat on the same head beat.
        drive(fx, fy, 1'b1, 1'b0);
        bus.i_success = 1'b1;
        @(negedge clk);
        chk("succ_eat", 16'(bus.o_eat), 16'd0);
        chk("succ_valid", 16'(bus.o_food_valid), 16'd0);
        bus.i_success = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("done_valid", 16'(bus.o_food_valid), 16'd0);
            chk("done_eat", 16'(bus.o_eat), 16'd0);
        end
        idle();

        // Reset from DONE, then asynchronous reset in the middle of CHECK.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        place();
        chk("rerun_x", 16'(bus.o_food_x), 16'd1);
        chk("rerun_y", 16'(bus.o_food_y), 16'd12);
        drive(5'd0, 4'd1, 1'b1, 1'b0);
        @(negedge clk);
        idle();
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 16'(bus.o_food_valid), 16'd0);
        chk("async_eat", 16'(bus.o_eat), 16'd0);
        chk("async_x", 16'(bus.o_food_x), 16'd0);
        chk("async_y", 16'(bus.o_food_y), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        place();
        chk("restart_x", 16'(bus.o_food_x), 16'd1);
        chk("restart_y", 16'(bus.o_food_y), 16'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
